// File: rtl/spi_master_seq.sv
// Transaction sequencer for an SPI shift-register datapath in master mode:
// load word, assert slave select, clock N pulses, return the received word.
module spi_master_seq #(
  parameter int word_width = 8,
  parameter int send_width = 1,
  parameter int SS_width   = 1,
  parameter int CLK_DIV    = 2,
  localparam int SSV_W     = $clog2((SS_width > 2) ? SS_width : 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [SSV_W-1:0]      slave_sel,
  input  logic [word_width-1:0] tx_data,
  output logic [word_width-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_SE,
  output logic                  spi_WE,
  output logic                  spi_SSE,
  output logic [SSV_W-1:0]      spi_SSV,
  output logic                  spi_SCLK,
  output logic [word_width-1:0] spi_D_IN,
  input  logic [word_width-1:0] spi_D_OUT
);

  localparam int N  = word_width / send_width;
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] HALF_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_END   = CW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] LAST_PULSE = PW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t        state;
  logic          cpol_r;
  logic          cpha_r;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      cnt      <= '0;
      pulse    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_SE   <= 1'b0;
      spi_WE   <= 1'b0;
      spi_SSE  <= 1'b0;
      spi_SSV  <= '0;
      spi_SCLK <= 1'b0;
      spi_D_IN <= '0;
    end else if (state != IDLE && abort) begin
      // Cancel: park the bus at the idle level of the current mode, no done pulse.
      state    <= IDLE;
      cnt      <= '0;
      pulse    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_WE   <= 1'b0;
      spi_SSE  <= 1'b0;
      spi_SCLK <= cpol_r;
      spi_SE   <= cpol_r ^ cpha_r;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cpol_r   <= cpol;
          cpha_r   <= cpha;
          spi_SE   <= cpol ^ cpha;
          spi_SCLK <= cpol;
          cnt      <= '0;
          pulse    <= '0;
          if (start && !abort) begin
            spi_D_IN <= tx_data;
            spi_SSV  <= slave_sel;
            busy     <= 1'b1;
            spi_WE   <= 1'b1;
            spi_SCLK <= ~cpol;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // One full SCLK pulse with SSE low yields exactly one load edge in any mode.
          cnt <= cnt + 1'b1;
          if (cnt == HALF_END) spi_SCLK <= cpol_r;
          if (cnt == FULL_END) begin
            cnt     <= '0;
            spi_WE  <= 1'b0;
            spi_SSE <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF_END) begin
            cnt      <= '0;
            spi_SCLK <= ~cpol_r;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF_END) spi_SCLK <= cpol_r;
          if (cnt == FULL_END) begin
            cnt <= '0;
            if (pulse == LAST_PULSE) begin
              pulse <= '0;
              state <= HOLD;
            end else begin
              pulse    <= pulse + 1'b1;
              spi_SCLK <= ~cpol_r;
            end
          end
        end
        HOLD: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF_END) begin
            cnt     <= '0;
            spi_SSE <= 1'b0;
            rx_data <= spi_D_OUT;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq: two instances (default config and a
// 4-slave, 2-bit-per-pulse config), each attached to a behavioural datapath.
`timescale 1ns/1ps
module tb_spi_master_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: word 8, send 1, one slave, CLK_DIV 2.
  logic       start = 1'b0, abort = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [0:0] slave_sel = '0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data, spi_D_IN;
  logic       busy, done, spi_SE, spi_WE, spi_SSE, spi_SCLK;
  logic [0:0] spi_SSV;
  logic [7:0] dp_sr = '0;

  spi_master_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cpol(cpol), .cpha(cpha),
    .slave_sel(slave_sel), .tx_data(tx_data), .rx_data(rx_data), .busy(busy),
    .done(done), .spi_SE(spi_SE), .spi_WE(spi_WE), .spi_SSE(spi_SSE),
    .spi_SSV(spi_SSV), .spi_SCLK(spi_SCLK), .spi_D_IN(spi_D_IN), .spi_D_OUT(dp_sr)
  );

  // Second instance: 4 slaves, 2 bits per pulse.
  logic       b_start = 1'b0, b_abort = 1'b0, b_cpol = 1'b0, b_cpha = 1'b0;
  logic [1:0] b_sel = '0;
  logic [7:0] b_tx = '0;
  logic [7:0] b_rx, b_D_IN;
  logic       b_busy, b_done, b_SE, b_WE, b_SSE, b_SCLK;
  logic [1:0] b_SSV;
  logic [7:0] b_sr = '0;

  spi_master_seq #(.word_width(8), .send_width(2), .SS_width(4), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .cpol(b_cpol), .cpha(b_cpha),
    .slave_sel(b_sel), .tx_data(b_tx), .rx_data(b_rx), .busy(b_busy),
    .done(b_done), .spi_SE(b_SE), .spi_WE(b_WE), .spi_SSE(b_SSE),
    .spi_SSV(b_SSV), .spi_SCLK(b_SCLK), .spi_D_IN(b_D_IN), .spi_D_OUT(b_sr)
  );

  int checks = 0;
  int passed = 0;

  // Datapath + slave models, sampled mid-cycle so registered outputs are settled.
  logic       loopback = 1'b1;
  logic [7:0] slave_seed = '0;
  logic [7:0] slave_sr = '0;
  logic       e_prev = 1'b0, sclk_prev = 1'b0;
  int         loads = 0, shifts = 0, toggles = 0;
  logic       miso, mosi, e;

  always @(negedge clk) begin
    e = spi_SE ^ spi_SCLK;
    if (e && !e_prev) begin
      if (spi_SSE) begin
        mosi     = dp_sr[7];
        miso     = loopback ? dp_sr[7] : slave_sr[7];
        dp_sr    = {dp_sr[6:0], miso};
        slave_sr = {slave_sr[6:0], mosi};
        shifts++;
      end else if (spi_WE) begin
        dp_sr    = spi_D_IN;
        slave_sr = slave_seed;
        loads++;
      end
    end
    if (spi_SCLK != sclk_prev) toggles++;
    e_prev    = e;
    sclk_prev = spi_SCLK;
  end

  logic       be_prev = 1'b0;
  logic       be;
  logic [3:0] ss_out;
  int         b_loads = 0, b_shifts = 0, b_ss_cycles = 0, b_ss_bad = 0;

  always @(negedge clk) begin
    be = b_SE ^ b_SCLK;
    if (be && !be_prev) begin
      if (b_SSE) begin
        b_sr = {b_sr[5:0], b_sr[7:6]};
        b_shifts++;
      end else if (b_WE) begin
        b_sr = b_D_IN;
        b_loads++;
      end
    end
    ss_out = b_SSE ? (4'b0001 << b_SSV) : 4'b0000;
    if (ss_out == 4'b1000) b_ss_cycles++;
    else if (ss_out != 4'b0000) b_ss_bad++;
    be_prev = be;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic pol, input logic pha, input logic [0:0] sel,
                         input logic [7:0] tx);
    cpol = pol; cpha = pha; slave_sel = sel; tx_data = tx; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Latency counted in edges from the accepting edge (which counts as 1).
  task automatic wait_done_a(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if ({busy, done, spi_SSE, spi_WE, spi_SCLK, spi_SE} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, spi_SSE, spi_WE, spi_SCLK, spi_SE});
    else passed++;
    checks++; if ({rx_data, spi_D_IN} !== 16'h0)
      $display("FAIL reset_data: got %h expected 0000", {rx_data, spi_D_IN}); else passed++;
    start_a(1'b0, 1'b0, 1'b0, 8'hFF);
    repeat (12) tick();
    checks++; if (spi_SSE !== 1'b1) $display("FAIL midrun_sse: got %b expected 1", spi_SSE); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, spi_SSE, spi_WE, spi_SCLK, spi_SE} !== 6'b0)
      $display("FAIL async_reset_ctrl: got %b expected 000000", {busy, done, spi_SSE, spi_WE, spi_SCLK, spi_SE});
    else passed++;
    checks++; if ({spi_D_IN, spi_SSV} !== 9'h0)
      $display("FAIL async_reset_data: got %h expected 000", {spi_D_IN, spi_SSV}); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy); else passed++;
    start_a(1'b0, 1'b0, 1'b0, 8'h12);
    checks++; if (busy !== 1'b1) $display("FAIL post_reset_accept: got %b expected 1", busy); else passed++;
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
  endtask

  task automatic test_loopback_mode0();
    int lat, l0, s0, t0;
    loopback = 1'b1;
    l0 = loads; s0 = shifts; t0 = toggles;
    start_a(1'b0, 1'b0, 1'b0, 8'hA5);
    checks++; if (busy !== 1'b1) $display("FAIL m0_accept: got %b expected 1", busy); else passed++;
    wait_done_a(lat);
    checks++; if (lat != 41) $display("FAIL m0_latency: got %0d expected 41", lat); else passed++;
    checks++; if (rx_data !== 8'hA5) $display("FAIL m0_rx: got %h expected a5", rx_data); else passed++;
    checks++; if (toggles - t0 != 18) $display("FAIL m0_sclk_edges: got %0d expected 18", toggles - t0); else passed++;
    checks++; if (loads - l0 != 1) $display("FAIL m0_loads: got %0d expected 1", loads - l0); else passed++;
    checks++; if (shifts - s0 != 8) $display("FAIL m0_shifts: got %0d expected 8", shifts - s0); else passed++;
    tick();
    checks++; if ({done, busy} !== 2'b00) $display("FAIL m0_after_done: got %b expected 00", {done, busy}); else passed++;
  endtask

  task automatic test_mode3();
    int lat;
    cpol = 1'b0; cpha = 1'b1;
    tick(); tick();
    checks++; if ({spi_SCLK, spi_SE} !== 2'b01) $display("FAIL m1_idle: got %b expected 01", {spi_SCLK, spi_SE}); else passed++;
    cpol = 1'b1; cpha = 1'b1;
    tick(); tick();
    checks++; if ({spi_SCLK, spi_SE} !== 2'b10) $display("FAIL m3_idle: got %b expected 10", {spi_SCLK, spi_SE}); else passed++;
    loopback = 1'b0; slave_seed = 8'hC3;
    start_a(1'b1, 1'b1, 1'b0, 8'h3C);
    checks++; if (spi_SE !== 1'b0) $display("FAIL m3_se: got %b expected 0", spi_SE); else passed++;
    wait_done_a(lat);
    checks++; if (lat != 41) $display("FAIL m3_latency: got %0d expected 41", lat); else passed++;
    checks++; if (rx_data !== 8'hC3) $display("FAIL m3_rx: got %h expected c3", rx_data); else passed++;
    checks++; if (slave_sr !== 8'h3C) $display("FAIL m3_mosi: got %h expected 3c", slave_sr); else passed++;
    checks++; if (spi_SCLK !== 1'b1) $display("FAIL m3_sclk_rest: got %b expected 1", spi_SCLK); else passed++;
    cpol = 1'b0; cpha = 1'b0; loopback = 1'b1;
    tick(); tick();
  endtask

  task automatic test_start_ignored();
    int lat, l0;
    l0 = loads;
    start_a(1'b0, 1'b0, 1'b0, 8'h96);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 15) begin start = 1'b1; tx_data = 8'h00; end
      tick();
      start = 1'b0;
      lat++;
    end
    checks++; if (lat != 41) $display("FAIL busy_start_latency: got %0d expected 41", lat); else passed++;
    checks++; if (loads - l0 != 1) $display("FAIL busy_start_loads: got %0d expected 1", loads - l0); else passed++;
    checks++; if (rx_data !== 8'h96) $display("FAIL busy_start_rx: got %h expected 96", rx_data); else passed++;
    start = 1'b1; tx_data = 8'h11;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL done_cycle_start: got %b expected 0", busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL not_queued: got %b expected 0", busy); else passed++;
    start_a(1'b0, 1'b0, 1'b0, 8'h69);
    checks++; if (busy !== 1'b1) $display("FAIL restart_accept: got %b expected 1", busy); else passed++;
    wait_done_a(lat);
    checks++; if (rx_data !== 8'h69) $display("FAIL restart_rx: got %h expected 69", rx_data); else passed++;
    tick();
  endtask

  task automatic test_abort();
    int lat, dones;
    start_a(1'b0, 1'b0, 1'b0, 8'hF0);
    repeat (15) tick();
    checks++; if (spi_SSE !== 1'b1) $display("FAIL abort_pre_sse: got %b expected 1", spi_SSE); else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({spi_SSE, busy, spi_WE, spi_SCLK} !== 4'b0000)
      $display("FAIL abort_idle: got %b expected 0000", {spi_SSE, busy, spi_WE, spi_SCLK});
    else passed++;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++; if (dones != 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else passed++;
    checks++; if (rx_data !== 8'h69) $display("FAIL abort_rx_kept: got %h expected 69", rx_data); else passed++;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_blocks_start: got %b expected 0", busy); else passed++;
    start_a(1'b0, 1'b0, 1'b0, 8'h5A);
    wait_done_a(lat);
    checks++; if (lat != 41) $display("FAIL post_abort_latency: got %0d expected 41", lat); else passed++;
    checks++; if (rx_data !== 8'h5A) $display("FAIL post_abort_rx: got %h expected 5a", rx_data); else passed++;
    tick();
  endtask

  task automatic test_ss_width();
    int lat, l0, s0, c0, x0;
    l0 = b_loads; s0 = b_shifts; c0 = b_ss_cycles; x0 = b_ss_bad;
    b_sel = 2'd3; b_tx = 8'hB4; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    lat = 1;
    while (b_done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++; if (lat != 25) $display("FAIL ss_latency: got %0d expected 25", lat); else passed++;
    checks++; if (b_rx !== 8'hB4) $display("FAIL ss_rx: got %h expected b4", b_rx); else passed++;
    checks++; if (b_shifts - s0 != 4) $display("FAIL ss_shifts: got %0d expected 4", b_shifts - s0); else passed++;
    checks++; if (b_loads - l0 != 1) $display("FAIL ss_loads: got %0d expected 1", b_loads - l0); else passed++;
    checks++; if (b_ss_cycles - c0 != 20) $display("FAIL ss_active_cycles: got %0d expected 20", b_ss_cycles - c0); else passed++;
    checks++; if (b_ss_bad - x0 != 0) $display("FAIL ss_wrong_line: got %0d expected 0", b_ss_bad - x0); else passed++;
    checks++; if (b_SSV !== 2'd3) $display("FAIL ss_ssv: got %0d expected 3", b_SSV); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_loopback_mode0();
    test_mode3();
    test_start_ignored();
    test_abort();
    test_ss_width();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
